ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Pipeline register between the execute ALU and the data-memory stage of the pipelined KGP-RISC core.
- Captures the ALU result, zero flag and control bits each cycle.
- Resolves conditional and unconditional branches from the ALU flags and drives a one-cycle PC redirect.
- Squashes the wrong-path instructions that follow a taken branch. Supports stall (hold) and flush (bubble insertion).

Parameters:
- BRANCH_SHADOW, 2: number of accepted slots after a taken branch that are squashed (range 1..3).
- REG_ADDR_W, 5: register-file address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold all state; input not accepted.
- flush  in  1  insert bubble this cycle; overrides stall.
- in_valid  in  1  execute-stage instruction valid.
- alu_out  in  32  ALU result (signed).
- alu_zero  in  1  ALU zero flag.
- branch_type  in  3  000 none, 001 b, 010 bz, 011 bnz, 100 bltz, 101 bl, 110 br (register jump).
- branch_target  in  32  precomputed target for 001..101.
- pc_plus4  in  32  PC+4 of the instruction.
- rd_addr  in  REG_ADDR_W  destination register.
- reg_write, mem_read, mem_write  in  1 each  control bits.
- store_data  in  32  store operand.
- out_valid  out  1  registered instruction valid.
- mem_addr  out  32  registered alu_out.
- mem_wdata  out  32  registered store_data.
- wb_data  out  32  registered writeback value.
- rd_out  out  REG_ADDR_W  registered rd_addr.
- reg_write_out, mem_read_out, mem_write_out  out  1 each  registered, gated by validity.
- redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  out  32  branch destination.

Behaviour:
- Reset: every output 0 and the shadow counter 0. Takes effect even mid-stall or mid-shadow.
- Latency: 1 cycle. Data captured at edge N appears on outputs after edge N.
- An input is accepted on any cycle with rst=0, flush=0 and stall=0.
- An accepted input is effective when `in_valid && shadow_cnt==0`. Otherwise it is captured as a bubble:
  - out_valid, reg_write_out, mem_read_out and mem_write_out are 0.
  - Data outputs may update; they are don't-care.
- Effective input updates:
  - out_valid <= 1.
  - mem_addr <= alu_out.
  - mem_wdata <= store_data.
  - rd_out <= rd_addr.
  - Control outputs follow their inputs.
  - wb_data <= pc_plus4 when branch_type==101, else alu_out.
- Taken condition:
  - 001, 101, 110: always taken.
  - 010: taken when alu_zero=1.
  - 011: taken when alu_zero=0.
  - 100: taken when alu_out[31]=1.
  - 000, 111: never taken.
- Redirect target: redirect_pc <= alu_out for 110, else branch_target.
- Effective taken branch: redirect_valid <= 1 and shadow_cnt <= BRANCH_SHADOW.
- redirect_valid is otherwise 0 on every edge, including stall edges. The pulse is exactly one cycle and is never extended by stall.
- Shadow counter: on each accepted cycle with shadow_cnt>0, the input is squashed and shadow_cnt decrements. This happens whether in_valid is 0 or 1, because bubbles occupy slots. A branch inside the shadow never redirects.
- Stall (flush=0): all registers hold, except redirect_valid, which clears. shadow_cnt holds.
- Flush: captures a bubble, clears shadow_cnt and clears redirect_valid, regardless of stall.
- Simultaneous flush and effective taken branch: flush wins; no redirect.
- Branch instructions with reg_write=0 still produce out_valid=1 (they pass down as no-ops).

Test Plan:
- Reset during active shadow with out_valid=1 -> next cycle all outputs 0, shadow_cnt=0, and the following valid input is accepted normally.
- ALU add: alu_out=0x0000_0010, reg_write=1, rd=3 -> after 1 edge: out_valid=1, wb_data=0x10, rd_out=3, redirect_valid=0.
- bz with alu_zero=1, branch_target=0x40, followed by 3 valid inputs -> redirect_valid high exactly one cycle with redirect_pc=0x40. Next 2 inputs produce out_valid=0; the 3rd produces out_valid=1. Repeat with alu_zero=0 -> no redirect and no squash.
- bl at pc_plus4=0x24 with target 0x100, and br with alu_out=0x80 -> bl: wb_data=0x24, redirect_pc=0x100. br: redirect_pc=0x80.
- bltz taken, then stall held 3 cycles -> redirect_valid high for 1 cycle only, outputs held, shadow still squashes 2 accepted slots after the stall releases.
- Taken bnz with flush=1 and stall=1 in the same cycle -> out_valid=0, no redirect. A second branch inside an active shadow -> squashed, no redirect.

Source files
------------

// File: rtl/ex_mem_if.sv
// Execute -> memory stage bus: stage controls, execute-side inputs and
// the registered outputs of the EX/MEM pipeline register.
interface ex_mem_if #(
    parameter int REG_ADDR_W = 5
);
    // Stage controls and execute-side inputs
    logic                  stall;
    logic                  flush;
    logic                  in_valid;
    logic [31:0]           alu_out;
    logic                  alu_zero;
    logic [2:0]            branch_type;
    logic [31:0]           branch_target;
    logic [31:0]           pc_plus4;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [31:0]           store_data;

    // Registered outputs toward the memory stage and fetch
    logic                  out_valid;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           wb_data;
    logic [REG_ADDR_W-1:0] rd_out;
    logic                  reg_write_out;
    logic                  mem_read_out;
    logic                  mem_write_out;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;

    // Handshake: there is no valid/ready backpressure. A slot is accepted
    // on every cycle with stall=0 and flush=0; flush overrides stall and
    // inserts a bubble. out_valid qualifies the registered outputs, and
    // redirect_valid is a single-cycle pulse that fetch must act on.

    // Execute side: drives inputs, observes the registered outputs
    modport master (
        output stall, flush, in_valid, alu_out, alu_zero, branch_type,
               branch_target, pc_plus4, rd_addr, reg_write, mem_read,
               mem_write, store_data,
        input  out_valid, mem_addr, mem_wdata, wb_data, rd_out,
               reg_write_out, mem_read_out, mem_write_out,
               redirect_valid, redirect_pc
    );

    // Pipeline register side
    modport slave (
        input  stall, flush, in_valid, alu_out, alu_zero, branch_type,
               branch_target, pc_plus4, rd_addr, reg_write, mem_read,
               mem_write, store_data,
        output out_valid, mem_addr, mem_wdata, wb_data, rd_out,
               reg_write_out, mem_read_out, mem_write_out,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register for the KGP-RISC core. Resolves branches from
// the ALU flags, issues a one-cycle fetch redirect and squashes the
// wrong-path slots that follow a taken branch.
module ex_mem_stage #(
    parameter int BRANCH_SHADOW = 2,
    parameter int REG_ADDR_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    ex_mem_if.slave     bus,
    output logic [1:0]  shadow_cnt
);
    localparam logic [2:0] BT_NONE = 3'b000;
    localparam logic [2:0] BT_B    = 3'b001;
    localparam logic [2:0] BT_BZ   = 3'b010;
    localparam logic [2:0] BT_BNZ  = 3'b011;
    localparam logic [2:0] BT_BLTZ = 3'b100;
    localparam logic [2:0] BT_BL   = 3'b101;
    localparam logic [2:0] BT_BR   = 3'b110;

    localparam logic [1:0] SHADOW_INIT = 2'(BRANCH_SHADOW);

    logic accept;
    logic effective;
    logic taken;

    // Branch condition from the ALU flags; 000 and 111 never redirect
    always_comb begin
        taken = 1'b0;
        case (bus.branch_type)
            BT_B, BT_BL, BT_BR: taken = 1'b1;
            BT_BZ:              taken = bus.alu_zero;
            BT_BNZ:             taken = ~bus.alu_zero;
            BT_BLTZ:            taken = bus.alu_out[31];
            BT_NONE:            taken = 1'b0;
            default:            taken = 1'b0;
        endcase
    end

    // A slot is accepted when neither held nor flushed; it only takes effect
    // outside the wrong-path shadow of an earlier taken branch.
    assign accept    = ~bus.stall & ~bus.flush;
    assign effective = accept & bus.in_valid & (shadow_cnt == 2'd0);

    // Pipeline register, redirect pulse and shadow counter
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid      <= 1'b0;
            bus.mem_addr       <= '0;
            bus.mem_wdata      <= '0;
            bus.wb_data        <= '0;
            bus.rd_out         <= '0;
            bus.reg_write_out  <= 1'b0;
            bus.mem_read_out   <= 1'b0;
            bus.mem_write_out  <= 1'b0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= '0;
            shadow_cnt         <= 2'd0;
        end else if (bus.flush) begin
            // Bubble; data outputs are don't-care and simply hold
            bus.out_valid      <= 1'b0;
            bus.reg_write_out  <= 1'b0;
            bus.mem_read_out   <= 1'b0;
            bus.mem_write_out  <= 1'b0;
            bus.redirect_valid <= 1'b0;
            shadow_cnt         <= 2'd0;
        end else if (bus.stall) begin
            // Hold everything; the redirect pulse must not stretch
            bus.redirect_valid <= 1'b0;
        end else begin
            // Data fields load on every accepted slot; validity gates them
            bus.mem_addr       <= bus.alu_out;
            bus.mem_wdata      <= bus.store_data;
            bus.rd_out         <= bus.rd_addr;
            bus.wb_data        <= (bus.branch_type == BT_BL) ? bus.pc_plus4
                                                             : bus.alu_out;
            bus.redirect_pc    <= (bus.branch_type == BT_BR) ? bus.alu_out
                                                             : bus.branch_target;
            bus.out_valid      <= effective;
            bus.reg_write_out  <= effective & bus.reg_write;
            bus.mem_read_out   <= effective & bus.mem_read;
            bus.mem_write_out  <= effective & bus.mem_write;
            bus.redirect_valid <= effective & taken;
            if (shadow_cnt != 2'd0)
                shadow_cnt <= shadow_cnt - 2'd1;
            else if (effective && taken)
                shadow_cnt <= SHADOW_INIT;
        end
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: ALU pass-through, loads/stores, every
// branch kind, shadow squashing, stall, flush and reset mid-shadow.
module tb_ex_mem_stage;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] shadow_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ex_mem_if #(.REG_ADDR_W(5)) bus ();

    ex_mem_stage #(.BRANCH_SHADOW(2), .REG_ADDR_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .shadow_cnt (shadow_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    // Single comparison point for every check
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle away from it before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] bt,
                         input logic [31:0] alu, input logic zero,
                         input logic [31:0] tgt, input logic [31:0] pc4,
                         input logic [4:0] rd, input logic rw,
                         input logic mr, input logic mw,
                         input logic [31:0] sd);
        bus.in_valid      = v;
        bus.branch_type   = bt;
        bus.alu_out       = alu;
        bus.alu_zero      = zero;
        bus.branch_target = tgt;
        bus.pc_plus4      = pc4;
        bus.rd_addr       = rd;
        bus.reg_write     = rw;
        bus.mem_read      = mr;
        bus.mem_write     = mw;
        bus.store_data    = sd;
    endtask

    task automatic idle();
        drive(1'b0, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Plain ALU op writing alu value to rd
    task automatic alu_op(input logic [31:0] alu, input logic [4:0] rd);
        drive(1'b1, 3'b000, alu, alu == 32'h0, 32'h0, 32'h0, rd, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"},  {31'b0, bus.out_valid}, 32'h0);
        check({tag, ".mem_addr"},   bus.mem_addr, 32'h0);
        check({tag, ".mem_wdata"},  bus.mem_wdata, 32'h0);
        check({tag, ".wb_data"},    bus.wb_data, 32'h0);
        check({tag, ".rd_out"},     {27'b0, bus.rd_out}, 32'h0);
        check({tag, ".ctrl"},       {29'b0, bus.reg_write_out, bus.mem_read_out,
                                     bus.mem_write_out}, 32'h0);
        check({tag, ".redirect"},   {31'b0, bus.redirect_valid}, 32'h0);
        check({tag, ".redir_pc"},   bus.redirect_pc, 32'h0);
        check({tag, ".shadow"},     {30'b0, shadow_cnt}, 32'h0);
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        idle();

        // Reset state
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // ALU add: rd=3 gets 0x10
        alu_op(32'h0000_0010, 5'd3);
        tick();
        check("add.out_valid", {31'b0, bus.out_valid}, 32'h1);
        check("add.wb_data",   bus.wb_data, 32'h10);
        check("add.rd_out",    {27'b0, bus.rd_out}, 32'd3);
        check("add.reg_write", {31'b0, bus.reg_write_out}, 32'h1);
        check("add.redirect",  {31'b0, bus.redirect_valid}, 32'h0);

        // Load then store
        drive(1'b1, 3'b000, 32'h0000_1000, 1'b0, 32'h0, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        check("ld.mem_addr", bus.mem_addr, 32'h1000);
        check("ld.mem_read", {31'b0, bus.mem_read_out}, 32'h1);
        drive(1'b1, 3'b000, 32'h0000_2004, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
        tick();
        check("st.mem_wdata",  bus.mem_wdata, 32'hCAFE_F00D);
        check("st.mem_write",  {31'b0, bus.mem_write_out}, 32'h1);
        check("st.mem_read",   {31'b0, bus.mem_read_out}, 32'h0);
        check("st.reg_write",  {31'b0, bus.reg_write_out}, 32'h0);

        // bz taken -> redirect to 0x40, two squashed slots
        drive(1'b1, 3'b010, 32'h0, 1'b1, 32'h40, 32'h14, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("bz.out_valid", {31'b0, bus.out_valid}, 32'h1);
        check("bz.redirect",  {31'b0, bus.redirect_valid}, 32'h1);
        check("bz.redir_pc",  bus.redirect_pc, 32'h40);
        check("bz.shadow",    {30'b0, shadow_cnt}, 32'd2);
        alu_op(32'h1, 5'd5);
        tick();
        check("bz.s1.out_valid", {31'b0, bus.out_valid}, 32'h0);
        check("bz.s1.reg_write", {31'b0, bus.reg_write_out}, 32'h0);
        check("bz.s1.redirect",  {31'b0, bus.redirect_valid}, 32'h0);
        alu_op(32'h2, 5'd5);
        tick();
        check("bz.s2.out_valid", {31'b0, bus.out_valid}, 32'h0);
        check("bz.s2.shadow",    {30'b0, shadow_cnt}, 32'd0);
        alu_op(32'h3, 5'd5);
        tick();
        check("bz.s3.out_valid", {31'b0, bus.out_valid}, 32'h1);
        check("bz.s3.wb_data",   bus.wb_data, 32'h3);

        // bz not taken -> no redirect, next slot not squashed
        drive(1'b1, 3'b010, 32'h5, 1'b0, 32'h40, 32'h18, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("bznt.out_valid", {31'b0, bus.out_valid}, 32'h1);
        check("bznt.redirect",  {31'b0, bus.redirect_valid}, 32'h0);
        check("bznt.shadow",    {30'b0, shadow_cnt}, 32'd0);
        alu_op(32'h4, 5'd6);
        tick();
        check("bznt.next.out_valid", {31'b0, bus.out_valid}, 32'h1);

        // bl: link value is pc_plus4, target is branch_target
        drive(1'b1, 3'b101, 32'h999, 1'b0, 32'h100, 32'h24, 5'd31, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        check("bl.wb_data",   bus.wb_data, 32'h24);
        check("bl.redir_pc",  bus.redirect_pc, 32'h100);
        check("bl.redirect",  {31'b0, bus.redirect_valid}, 32'h1);
        check("bl.rd_out",    {27'b0, bus.rd_out}, 32'd31);
        // Bubbles occupy shadow slots
        idle();
        tick();
        tick();
        check("bl.shadow_drained", {30'b0, shadow_cnt}, 32'd0);

        // br: register jump takes alu_out
        drive(1'b1, 3'b110, 32'h80, 1'b0, 32'h200, 32'h30, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("br.redir_pc", bus.redirect_pc, 32'h80);
        check("br.redirect", {31'b0, bus.redirect_valid}, 32'h1);
        idle();
        tick();
        tick();

        // bltz with non-negative operand -> not taken
        drive(1'b1, 3'b100, 32'h7FFF_FFFF, 1'b0, 32'h300, 32'h34, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("bltz_nt.redirect", {31'b0, bus.redirect_valid}, 32'h0);

        // bltz taken, then 3 stall cycles
        drive(1'b1, 3'b100, 32'h8000_0000, 1'b0, 32'h500, 32'h38, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("bltz.redirect", {31'b0, bus.redirect_valid}, 32'h1);
        check("bltz.redir_pc", bus.redirect_pc, 32'h500);
        bus.stall = 1'b1;
        alu_op(32'h55, 5'd9);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.redirect",  {31'b0, bus.redirect_valid}, 32'h0);
            check("stall.out_valid", {31'b0, bus.out_valid}, 32'h1);
            check("stall.mem_addr",  bus.mem_addr, 32'h8000_0000);
            check("stall.shadow",    {30'b0, shadow_cnt}, 32'd2);
        end
        bus.stall = 1'b0;
        tick();
        check("post_stall.s1.out_valid", {31'b0, bus.out_valid}, 32'h0);
        tick();
        check("post_stall.s2.out_valid", {31'b0, bus.out_valid}, 32'h0);
        tick();
        check("post_stall.s3.out_valid", {31'b0, bus.out_valid}, 32'h1);
        check("post_stall.s3.wb_data",   bus.wb_data, 32'h55);

        // Taken bnz with flush and stall together -> bubble, no redirect
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        drive(1'b1, 3'b011, 32'h1, 1'b0, 32'h600, 32'h3C, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("flush.out_valid", {31'b0, bus.out_valid}, 32'h0);
        check("flush.redirect",  {31'b0, bus.redirect_valid}, 32'h0);
        check("flush.shadow",    {30'b0, shadow_cnt}, 32'd0);
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        alu_op(32'h66, 5'd10);
        tick();
        check("flush.next.out_valid", {31'b0, bus.out_valid}, 32'h1);

        // Flush clears an active shadow
        drive(1'b1, 3'b001, 32'h0, 1'b0, 32'h700, 32'h40, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("b.shadow", {30'b0, shadow_cnt}, 32'd2);
        bus.flush = 1'b1;
        alu_op(32'h11, 5'd2);
        tick();
        check("flush_shadow.shadow", {30'b0, shadow_cnt}, 32'd0);
        bus.flush = 1'b0;
        tick();
        check("flush_shadow.next.out_valid", {31'b0, bus.out_valid}, 32'h1);

        // Branch inside an active shadow is squashed
        drive(1'b1, 3'b001, 32'h0, 1'b0, 32'h800, 32'h44, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("b1.redirect", {31'b0, bus.redirect_valid}, 32'h1);
        drive(1'b1, 3'b001, 32'h0, 1'b0, 32'h900, 32'h48, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("b2.redirect",  {31'b0, bus.redirect_valid}, 32'h0);
        check("b2.out_valid", {31'b0, bus.out_valid}, 32'h0);
        check("b2.shadow",    {30'b0, shadow_cnt}, 32'd1);
        idle();
        tick();
        check("b2.shadow_drained", {30'b0, shadow_cnt}, 32'd0);

        // Reset during an active shadow with out_valid=1
        drive(1'b1, 3'b001, 32'h0, 1'b0, 32'hA00, 32'h4C, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("pre_rst.out_valid", {31'b0, bus.out_valid}, 32'h1);
        rst = 1'b1;
        bus.stall = 1'b1;
        alu_op(32'h77, 5'd4);
        tick();
        check_all_zero("rst_shadow");
        rst = 1'b0;
        bus.stall = 1'b0;
        tick();
        check("rst_shadow.next.out_valid", {31'b0, bus.out_valid}, 32'h1);
        check("rst_shadow.next.wb_data",   bus.wb_data, 32'h77);
        check("rst_shadow.next.rd_out",    {27'b0, bus.rd_out}, 32'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
